sram_ctrl: RTL and testbench
============================

# sram_ctrl

Avalon-MM slave that turns single-word read/write transfers into timed cycles on an external asynchronous SRAM. It is the stage directly downstream of the Avalon-MM master:
- It consumes address/read/write/byteenable/writedata.
- It returns readdata/readdatavalid and throttles the master with waitrequest.
- It drives the SRAM pins through a split tristate data bus.

## Interface
One clock; reset is asynchronous and active-low.
- ADDR_W, 20, word address width (Avalon and SRAM)
- DATA_W, 16, data width; multiple of 8; BE_W = DATA_W/8
- READ_WAIT, 2, cycles the SRAM is held in a read access (>=1)
- WRITE_WAIT, 2, cycles we_n is held low (>=1)
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_byteenable  in  BE_W  write byte mask
- avs_writedata  in  DATA_W  write data
- avs_waitrequest  out  1  1 = request not accepted
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  one-cycle read-data strobe
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_o  out  DATA_W  data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_i  in  DATA_W  data from pad
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_be_n  out  BE_W  byte lanes, active low

## Operation
- All outputs are registered.
- Reset values:
  - avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0
  - sram_ce_n/oe_n/we_n=1, sram_be_n all 1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0
  - state IDLE
- FSM states: IDLE, RD, WR, TURN.
- IDLE:
  - avs_waitrequest=0.
  - A request is accepted on a clk edge where waitrequest=0 and read or write=1.
  - If read and write are both 1, write wins; this is an illegal Avalon request.
- RD, entered on accept:
  - Drive sram_addr=address, ce_n=0, oe_n=0, be_n all 0, dq_oe=0.
  - Stay READ_WAIT cycles, using a down-counter loaded with READ_WAIT-1.
  - At the edge that leaves RD, capture sram_dq_i into avs_readdata.
  - Then go to TURN.
- WR, entered on accept:
  - Drive addr, dq_o=writedata, dq_oe=1, ce_n=0, we_n=0, be_n=~byteenable.
  - Stay WRITE_WAIT cycles, then go to TURN.
  - byteenable=0 still runs a full cycle with all lanes masked.
- TURN (one cycle):
  - ce_n=1, oe_n=1, we_n=1.
  - After a write, dq_oe and dq_o stay driven for data hold, then drop on exit.
  - After a read, avs_readdatavalid=1 for exactly this cycle.
  - Next state is IDLE.
- avs_waitrequest:
  - Set to 1 on the accepting edge.
  - Cleared on the edge entering IDLE.
- Reset asserted mid-cycle immediately forces all reset values:
  - Any pending readdatavalid is lost.
  - A partial SRAM write is permitted.

## Timing
- Read accepted at edge T:
  - RD occupies cycles T+1 .. T+READ_WAIT.
  - avs_readdatavalid is high in cycle T+READ_WAIT+1.
  - Next accept is possible at edge T+READ_WAIT+2.
- Write accepted at edge T:
  - we_n is low in cycles T+1 .. T+WRITE_WAIT.
  - Next accept at edge T+WRITE_WAIT+2.
- Throughput: one transfer per READ_WAIT+2 (read) or WRITE_WAIT+2 (write) cycles; no pipelining, at most one outstanding read.
- After rst_n release: waitrequest stays 1 until the first clk edge, then drops to 0.
- we_n and oe_n are never low in the same cycle.
- dq_oe is never 1 while oe_n=0.

## Structure
- Package sram_ctrl_pkg holds:
  - the state enum typedef (IDLE, RD, WR, TURN)
  - a function computing counter width from max(READ_WAIT, WRITE_WAIT)
- Single module; no sub-module. The wait counter is inline.
- Elaboration-time assertions: DATA_W%8==0, READ_WAIT>=1, WRITE_WAIT>=1.

## Test plan
- Reset check: rst_n low for 3 cycles.
  - All outputs hold their reset values.
  - waitrequest=1 until the first edge after release, then 0.
- Write then read, READ_WAIT=WRITE_WAIT=2, SRAM model attached:
  - Write addr 0x00012, data 0xBEEF, be=2'b11: we_n low exactly 2 cycles.
  - Read addr 0x00012: readdatavalid at T+3 with 0xBEEF.
- Byte-lane write to the same address:
  - Write 0x1234 with be=2'b01, then read: returns 0xBE34.
  - During the write, sram_be_n=2'b10.
- Back-to-back traffic: master holds read=1 continuously over 4 addresses.
  - Accepts are exactly 4 cycles apart.
  - Exactly 4 readdatavalid pulses, in order.
- Illegal request: read=1 and write=1 together at addr 0x3.
  - A write is performed.
  - No readdatavalid.
- Reset mid-read: rst_n dropped in the second RD cycle.
  - ce_n/oe_n return to 1 asynchronously.
  - No readdatavalid ever appears.
  - The next read after release completes normally.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and elaboration helpers for the asynchronous SRAM controller.
package sram_ctrl_pkg;

  // Controller phases: idle/accepting, read access, write access, bus turnaround.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } state_e;

  // Width of the wait down-counter. It is loaded with (wait - 1), so it must
  // hold values 0 .. max(read_wait, write_wait) - 1, and never be zero bits wide.
  function automatic int cnt_width(input int read_wait, input int write_wait);
    int m;
    m = (read_wait > write_wait) ? read_wait : write_wait;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Avalon-MM slave driving a single-word asynchronous SRAM. One transfer in
// flight at a time: IDLE accepts, RD/WR hold the access for a fixed number of
// cycles, TURN releases the chip (and keeps write data on the bus for hold).
//
// Handshake: a request is accepted on a clk edge where avs_waitrequest=0 and
// avs_read or avs_write is 1 (write wins if both); waitrequest rises on that
// edge and falls again on the edge that returns to IDLE. avs_readdatavalid is
// a one-cycle strobe with no backpressure.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_dq_o,
  output logic                sram_dq_oe,
  input  logic [DATA_W-1:0]   sram_dq_i,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = cnt_width(READ_WAIT, WRITE_WAIT);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("sram_ctrl: DATA_W must be a multiple of 8");
  end
  if (READ_WAIT < 1) begin : g_bad_read_wait
    $error("sram_ctrl: READ_WAIT must be >= 1");
  end
  if (WRITE_WAIT < 1) begin : g_bad_write_wait
    $error("sram_ctrl: WRITE_WAIT must be >= 1");
  end

  state_e            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              wait_q,    wait_d;
  logic              rdv_q,     rdv_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0] dq_o_q,    dq_o_d;
  logic              dq_oe_q,   dq_oe_d;
  logic              ce_n_q,    ce_n_d;
  logic              oe_n_q,    oe_n_d;
  logic              we_n_q,    we_n_d;
  logic [BE_W-1:0]   be_n_q,    be_n_d;

  // Next state and next values of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = dq_oe_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    be_n_d  = be_n_q;
    case (state_q)
      IDLE: begin
        wait_d = 1'b0;
        if (!wait_q && (avs_write || avs_read)) begin
          wait_d = 1'b1;
          addr_d = avs_address;
          ce_n_d = 1'b0;
          if (avs_write) begin
            state_d = WR;
            cnt_d   = WR_LOAD;
            dq_o_d  = avs_writedata;
            dq_oe_d = 1'b1;
            we_n_d  = 1'b0;
            be_n_d  = ~avs_byteenable;
          end else begin
            state_d = RD;
            cnt_d   = RD_LOAD;
            dq_oe_d = 1'b0;
            oe_n_d  = 1'b0;
            be_n_d  = '0;
          end
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          rdata_d = sram_dq_i;
          rdv_d   = 1'b1;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          be_n_d  = '1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR: begin
        if (cnt_q == '0) begin
          state_d = TURN;
          ce_n_d  = 1'b1;
          we_n_d  = 1'b1;
          be_n_d  = '1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN: begin
        // Write data was held through this cycle; release the bus now.
        state_d = IDLE;
        wait_d  = 1'b0;
        dq_oe_d = 1'b0;
        dq_o_d  = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset to the idle bus values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b1;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      rdv_q   <= rdv_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
    end
  end

  assign avs_waitrequest   = wait_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rdv_q;
  assign sram_addr         = addr_q;
  assign sram_dq_o         = dq_o_q;
  assign sram_dq_oe        = dq_oe_q;
  assign sram_ce_n         = ce_n_q;
  assign sram_oe_n         = oe_n_q;
  assign sram_we_n         = we_n_q;
  assign sram_be_n         = be_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: Avalon master driver tasks, an asynchronous SRAM
// device model on the pins, and a word-level reference memory for expected data.
module tb_sram_ctrl;

  localparam int ADDR_W     = 20;
  localparam int DATA_W     = 16;
  localparam int BE_W       = 2;
  localparam int READ_WAIT  = 2;
  localparam int WRITE_WAIT = 2;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [BE_W-1:0]   avs_byteenable;
  logic [DATA_W-1:0] avs_writedata;
  logic              avs_waitrequest;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic [BE_W-1:0]   sram_be_n;

  int total = 0;
  int bad   = 0;

  sram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT), .WRITE_WAIT(WRITE_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_byteenable(avs_byteenable), .avs_writedata(avs_writedata),
    .avs_waitrequest(avs_waitrequest), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM device model ----------------
  logic [DATA_W-1:0] dev_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] dev_w;

  always @(sram_addr or sram_ce_n or sram_oe_n) begin
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_i = dev_mem.exists(sram_addr) ? dev_mem[sram_addr] : '0;
    else
      sram_dq_i = 16'hDEAD;
  end

  always @(posedge clk) begin
    if (rst_n && !sram_ce_n && !sram_we_n && sram_dq_oe) begin
      dev_w = dev_mem.exists(sram_addr) ? dev_mem[sram_addr] : '0;
      for (int b = 0; b < BE_W; b++)
        if (!sram_be_n[b]) dev_w[8*b +: 8] = sram_dq_o[8*b +: 8];
      dev_mem[sram_addr] = dev_w;
    end
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] w;
    w = ref_read(a);
    for (int b = 0; b < BE_W; b++)
      if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endtask

  // ---------------- pin monitor / scoreboard queues ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] rdv_data_q[$];
  int                rdv_cyc_q[$];
  int                we_cnt;
  int                we_first;
  logic [BE_W-1:0]   be_obs;
  int                viol = 0;

  always @(negedge clk) begin
    if (rst_n && avs_readdatavalid) begin
      rdv_data_q.push_back(avs_readdata);
      rdv_cyc_q.push_back(cyc);
    end
    if (!sram_we_n) begin
      we_cnt = we_cnt + 1;
      if (we_cnt == 1) we_first = cyc;
      be_obs = sram_be_n;
    end
    if (!sram_we_n && !sram_oe_n) viol++;
    if (sram_dq_oe && !sram_oe_n) viol++;
  end

  // ---------------- driver tasks ----------------
  // waitrequest only moves on posedge, so a low value now means the next edge accepts.
  task automatic wait_accept(output int acc, output bit ok);
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      if (!avs_waitrequest) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic drv_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [BE_W-1:0] be, input bit both,
                           output int acc, output bit ok,
                           output logic turn_oe, output logic [DATA_W-1:0] turn_dq,
                           output logic idle_oe);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    avs_read       = both;
    we_cnt         = 0;
    we_first       = -1;
    wait_accept(acc, ok);
    avs_write = 1'b0;
    avs_read  = 1'b0;
    repeat (WRITE_WAIT + 1) @(negedge clk);
    turn_oe = sram_dq_oe;
    turn_dq = sram_dq_o;
    @(negedge clk);
    idle_oe = sram_dq_oe;
    #1;
  endtask

  task automatic drv_read(input logic [ADDR_W-1:0] a, output int acc, output bit ok,
                          output logic [DATA_W-1:0] data, output int rcyc,
                          output bit got, output int extra);
    avs_address = a;
    avs_read    = 1'b1;
    avs_write   = 1'b0;
    got  = 1'b0;
    data = 'x;
    rcyc = -1;
    wait_accept(acc, ok);
    avs_read = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (rdv_data_q.size() > 0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      data = rdv_data_q.pop_front();
      rcyc = rdv_cyc_q.pop_front();
    end
    repeat (2) @(negedge clk);
    #1;
    extra = rdv_data_q.size();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [59:0] got_v;
    logic [59:0] exp_v;
    exp_v = {1'b1, 1'b0, 16'h0, 20'h0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11};
    rst_n = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_byteenable = '0; avs_writedata = '0;
    #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      got_v = {avs_waitrequest, avs_readdatavalid, avs_readdata, sram_addr, sram_dq_o,
               sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL reset_values: got %h want %h", got_v, exp_v);
      end
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (avs_waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL wait_after_release: got %b want 1", avs_waitrequest);
    end
    @(posedge clk);
    #1;
    total++;
    if (avs_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL wait_first_edge: got %b want 0", avs_waitrequest);
    end
  endtask

  task automatic test_write_read();
    int acc, rcyc, extra;
    bit ok, got;
    logic turn_oe, idle_oe;
    logic [DATA_W-1:0] turn_dq, data, exp_d;
    drv_write(20'h00012, 16'hBEEF, 2'b11, 1'b0, acc, ok, turn_oe, turn_dq, idle_oe);
    ref_write(20'h00012, 16'hBEEF, 2'b11);
    total++;
    if (!ok || we_cnt != WRITE_WAIT || we_first != acc) begin
      bad++;
      $display("FAIL wr_we_pulse: got ok=%0b cnt=%0d first=%0d want cnt=%0d first=%0d",
               ok, we_cnt, we_first, WRITE_WAIT, acc);
    end
    total++;
    if (be_obs !== 2'b00) begin
      bad++;
      $display("FAIL wr_be_n: got %b want 00", be_obs);
    end
    total++;
    if (turn_oe !== 1'b1 || turn_dq !== 16'hBEEF || idle_oe !== 1'b0) begin
      bad++;
      $display("FAIL wr_data_hold: got oe=%b dq=%h idle_oe=%b want 1 beef 0",
               turn_oe, turn_dq, idle_oe);
    end
    exp_q.push_back(ref_read(20'h00012));
    drv_read(20'h00012, acc, ok, data, rcyc, got, extra);
    exp_d = exp_q.pop_front();
    total++;
    if (!got || data !== exp_d) begin
      bad++;
      $display("FAIL rd_data: got %h (valid=%0b) want %h", data, got, exp_d);
    end
    total++;
    if (rcyc != acc + READ_WAIT) begin
      bad++;
      $display("FAIL rd_latency: got cyc %0d want %0d", rcyc, acc + READ_WAIT);
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL rd_single_pulse: got %0d extra strobes want 0", extra);
    end
  endtask

  task automatic test_byte_lanes();
    int acc, rcyc, extra;
    bit ok, got;
    logic turn_oe, idle_oe;
    logic [DATA_W-1:0] turn_dq, data, exp_d;
    drv_write(20'h00012, 16'h1234, 2'b01, 1'b0, acc, ok, turn_oe, turn_dq, idle_oe);
    ref_write(20'h00012, 16'h1234, 2'b01);
    total++;
    if (!ok || be_obs !== 2'b10) begin
      bad++;
      $display("FAIL be_low_lane: got ok=%0b be_n=%b want 10", ok, be_obs);
    end
    drv_read(20'h00012, acc, ok, data, rcyc, got, extra);
    exp_d = ref_read(20'h00012);
    total++;
    if (!got || data !== exp_d) begin
      bad++;
      $display("FAIL be_merge_read: got %h want %h", data, exp_d);
    end
    // All lanes masked: full-length cycle, memory untouched.
    drv_write(20'h00012, 16'h5A5A, 2'b00, 1'b0, acc, ok, turn_oe, turn_dq, idle_oe);
    ref_write(20'h00012, 16'h5A5A, 2'b00);
    total++;
    if (!ok || we_cnt != WRITE_WAIT || be_obs !== 2'b11) begin
      bad++;
      $display("FAIL be_zero_cycle: got cnt=%0d be_n=%b want %0d 11", we_cnt, be_obs, WRITE_WAIT);
    end
    drv_read(20'h00012, acc, ok, data, rcyc, got, extra);
    exp_d = ref_read(20'h00012);
    total++;
    if (!got || data !== exp_d) begin
      bad++;
      $display("FAIL be_zero_read: got %h want %h", data, exp_d);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a [4];
    int acc [4];
    int wacc;
    bit ok, all_ok;
    logic turn_oe, idle_oe;
    logic [DATA_W-1:0] turn_dq, d, exp_d;
    for (int i = 0; i < 4; i++) begin
      a[i] = ADDR_W'($urandom_range(0, 20'hFFFFF));
      d    = DATA_W'($urandom);
      drv_write(a[i], d, 2'b11, 1'b0, wacc, ok, turn_oe, turn_dq, idle_oe);
      ref_write(a[i], d, 2'b11);
    end
    all_ok = 1'b1;
    avs_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      avs_address = a[i];
      exp_q.push_back(ref_read(a[i]));
      wait_accept(acc[i], ok);
      if (!ok) all_ok = 1'b0;
    end
    avs_read = 1'b0;
    for (int i = 0; i < 20 && rdv_data_q.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (!all_ok || rdv_data_q.size() != 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d strobes (accepts ok=%0b) want 4", rdv_data_q.size(), all_ok);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (acc[i] - acc[i-1] != READ_WAIT + 2) begin
        bad++;
        $display("FAIL b2b_spacing: got %0d want %0d", acc[i] - acc[i-1], READ_WAIT + 2);
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = exp_q.pop_front();
      if (rdv_data_q.size() > 0) begin
        d = rdv_data_q.pop_front();
        wacc = rdv_cyc_q.pop_front();
        total++;
        if (d !== exp_d || wacc != acc[i] + READ_WAIT) begin
          bad++;
          $display("FAIL b2b_data: got %h@%0d want %h@%0d", d, wacc, exp_d, acc[i] + READ_WAIT);
        end
      end
    end
    rdv_data_q.delete();
    rdv_cyc_q.delete();
  endtask

  task automatic test_illegal();
    int acc, rcyc, extra;
    bit ok, got;
    logic turn_oe, idle_oe;
    logic [DATA_W-1:0] turn_dq, data, exp_d, d;
    d = DATA_W'($urandom);
    drv_write(20'h00003, d, 2'b11, 1'b1, acc, ok, turn_oe, turn_dq, idle_oe);
    ref_write(20'h00003, d, 2'b11);
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (!ok || we_cnt != WRITE_WAIT || rdv_data_q.size() != 0) begin
      bad++;
      $display("FAIL illegal_is_write: got cnt=%0d strobes=%0d want %0d 0",
               we_cnt, rdv_data_q.size(), WRITE_WAIT);
    end
    drv_read(20'h00003, acc, ok, data, rcyc, got, extra);
    exp_d = ref_read(20'h00003);
    total++;
    if (!got || data !== exp_d) begin
      bad++;
      $display("FAIL illegal_readback: got %h want %h", data, exp_d);
    end
  endtask

  task automatic test_reset_mid_read();
    int acc, rcyc, extra;
    bit ok, got;
    logic [DATA_W-1:0] data, exp_d;
    avs_address = 20'h00012;
    avs_read    = 1'b1;
    wait_accept(acc, ok);
    avs_read = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (!ok || sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      bad++;
      $display("FAIL async_reset_pins: got ce_n=%b oe_n=%b want 1 1", sram_ce_n, sram_oe_n);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    total++;
    if (rdv_data_q.size() != 0) begin
      bad++;
      $display("FAIL reset_lost_rdv: got %0d strobes want 0", rdv_data_q.size());
    end
    drv_read(20'h00012, acc, ok, data, rcyc, got, extra);
    exp_d = ref_read(20'h00012);
    total++;
    if (!got || data !== exp_d || rcyc != acc + READ_WAIT) begin
      bad++;
      $display("FAIL read_after_reset: got %h@%0d want %h@%0d", data, rcyc, exp_d, acc + READ_WAIT);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] pool [4];
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, data, exp_d, turn_dq;
    logic [BE_W-1:0]   be;
    logic turn_oe, idle_oe;
    int acc, rcyc, extra;
    bit ok, got;
    for (int i = 0; i < 4; i++) pool[i] = ADDR_W'($urandom_range(0, 20'hFFFFF));
    for (int n = 0; n < 24; n++) begin
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 1) == 1) begin
        d  = DATA_W'($urandom);
        be = BE_W'($urandom_range(0, 3));
        drv_write(a, d, be, 1'b0, acc, ok, turn_oe, turn_dq, idle_oe);
        ref_write(a, d, be);
        total++;
        if (!ok || we_cnt != WRITE_WAIT || be_obs !== ~be) begin
          bad++;
          $display("FAIL rnd_write: got cnt=%0d be_n=%b want %0d %b", we_cnt, be_obs, WRITE_WAIT, ~be);
        end
      end else begin
        drv_read(a, acc, ok, data, rcyc, got, extra);
        exp_d = ref_read(a);
        total++;
        if (!got || data !== exp_d || rcyc != acc + READ_WAIT || extra != 0) begin
          bad++;
          $display("FAIL rnd_read: addr %h got %h@%0d want %h@%0d", a, data, rcyc, exp_d,
                   acc + READ_WAIT);
        end
      end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL bus_invariants: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_illegal();
    test_reset_mid_read();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
